// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result streams with valid/ready handshakes on both sides
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract whose carry chain is split over STAGES registered chunks
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic reset,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  logic adv;
  logic [WIDTH-1:0] b_eff;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c;
  logic [WIDTH-1:0] ar [STAGES];
  logic [WIDTH-1:0] br [STAGES];
  logic [WIDTH-1:0] sr [STAGES];
  logic [CHUNK:0] r [STAGES];
  assign adv = bus.out_ready || !v[STAGES-1];
  assign bus.in_ready = adv && !reset;
  // subtraction is a + ~b + ~cin, so both b and the carry-in are inverted up front
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  always_comb begin
    r[0] = {1'b0, bus.a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + (CHUNK+1)'(bus.cin ^ bus.sub);
    for (int k = 1; k < STAGES; k++)
      r[k] = {1'b0, ar[k-1][k*CHUNK +: CHUNK]} + {1'b0, br[k-1][k*CHUNK +: CHUNK]} + (CHUNK+1)'(c[k-1]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v <= '0;
      c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ar[k] <= '0;
        br[k] <= '0;
        sr[k] <= '0;
      end
    end else if (adv) begin
      v[0] <= bus.in_valid;
      c[0] <= r[0][CHUNK];
      ar[0] <= bus.a;
      br[0] <= b_eff;
      sr[0] <= WIDTH'(r[0][CHUNK-1:0]);
      for (int k = 1; k < STAGES; k++) begin
        v[k] <= v[k-1];
        c[k] <= r[k][CHUNK];
        ar[k] <= ar[k-1];
        br[k] <= br[k-1];
        sr[k] <= sr[k-1];
        sr[k][k*CHUNK +: CHUNK] <= r[k][CHUNK-1:0];
      end
    end
  assign bus.out_valid = v[STAGES-1];
  assign bus.sum = sr[STAGES-1];
  assign bus.cout = c[STAGES-1];
  assign bus.ovf = (ar[STAGES-1][WIDTH-1] == br[STAGES-1][WIDTH-1]) &&
                   (sr[STAGES-1][WIDTH-1] != ar[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench driving a STAGES=4 and a STAGES=1 adder in turn
module tb_pipelined_adder;
  typedef struct {
    logic [31:0] s;
    logic c;
    logic o;
    int acc;
    int lat;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic ci;
    logic sb;
    logic [31:0] es;
    logic ec;
    logic eo;
  } vec_t;
  logic clk = 0;
  logic reset = 0;
  logic sel = 0;
  logic tv = 0;
  logic ordy = 1;
  logic rnd_bp = 0;
  logic [31:0] xa = 0;
  logic [31:0] xb = 0;
  logic xc = 0;
  logic xs = 0;
  logic ir, ov, oc, oo;
  logic [31:0] osum;
  logic held = 0;
  logic [31:0] hs;
  logic hc, ho;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  vec_t dv[7] = '{
    '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
    '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
    '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0}
  };

  pipelined_adder_if #(.WIDTH(32)) i4 ();
  pipelined_adder_if #(.WIDTH(32)) i1 ();
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (.clk(clk), .reset(reset), .bus(i4));
  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));

  assign i4.in_valid = tv && !sel;
  assign i1.in_valid = tv && sel;
  assign i4.a = xa;
  assign i1.a = xa;
  assign i4.b = xb;
  assign i1.b = xb;
  assign i4.cin = xc;
  assign i1.cin = xc;
  assign i4.sub = xs;
  assign i1.sub = xs;
  assign i4.out_ready = ordy;
  assign i1.out_ready = ordy;
  assign ir = sel ? i1.in_ready : i4.in_ready;
  assign ov = sel ? i1.out_valid : i4.out_valid;
  assign osum = sel ? i1.sum : i4.sum;
  assign oc = sel ? i1.cout : i4.cout;
  assign oo = sel ? i1.ovf : i4.ovf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd_bp) begin #1; ordy = ($urandom_range(0, 3) != 0); end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // reference: plain wide arithmetic, signed overflow from the true mathematical result
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
    exp_t e;
    logic [32:0] w;
    longint sv;
    if (sb) begin
      w = {1'b0, x} - {1'b0, y} - 33'(ci);
      e.c = ~w[32];
      sv = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
    end else begin
      w = {1'b0, x} + {1'b0, y} + 33'(ci);
      e.c = w[32];
      sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    end
    e.s = w[31:0];
    e.o = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o;
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb,
                       input int lat, input exp_t e);
    int n = 0;
    @(negedge clk);
    xa = x;
    xb = y;
    xc = ci;
    xs = sb;
    tv = 1;
    while (!ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stuck at 0 for %0d cycles", n);
    end else begin
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic send_rand(input int lat);
    logic [31:0] x, y;
    logic ci, sb;
    x = $urandom;
    y = $urandom;
    ci = 1'($urandom);
    sb = 1'($urandom);
    if ($urandom_range(0, 3) == 0) x = {x[31], {31{x[30]}}};
    if (lat == 0 && $urandom_range(0, 4) == 0) begin
      @(negedge clk);
      tv = 0;
    end
    issue(x, y, ci, sb, lat, model(x, y, ci, sb));
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    tv = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_size", 64'(q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // monitor: handshake rule, stall stability and in-order scoreboard compare
  always @(negedge clk) begin
    exp_t e;
    if (reset) held = 0;
    else begin
      if (held) begin
        chk("hold_out_valid", ov, 1);
        chk("hold_sum", osum, hs);
        chk("hold_cout", oc, hc);
        chk("hold_ovf", oo, ho);
      end
      held = ov && !ordy;
      hs = osum;
      hc = oc;
      ho = oo;
      chk("in_ready_rule", ir, ordy || !ov);
      if (ov && ordy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got sum %0h with no result outstanding", osum);
        end else begin
          e = q.pop_front();
          chk("sum", osum, e.s);
          chk("cout", oc, e.c);
          chk("ovf", oo, e.o);
          if (e.lat != 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    #1 reset = 1;
    #2;
    chk("rst_out_valid", i4.out_valid, 0);
    chk("rst_sum", i4.sum, 0);
    chk("rst_cout", i4.cout, 0);
    chk("rst_ovf", i4.ovf, 0);
    chk("rst_in_ready", i4.in_ready, 0);
    chk("rst1_out_valid", i1.out_valid, 0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("in_ready_after_release", ir, 1);
    foreach (dv[i]) issue(dv[i].a, dv[i].b, dv[i].ci, dv[i].sb, 4, mk(dv[i].es, dv[i].ec, dv[i].eo));
    drain();
    fork
      for (int i = 0; i < 8; i++) issue(32'(i), 32'(i) << 16, 1'b0, 1'b0, 0, mk(32'(i) + (32'(i) << 16), 1'b0, 1'b0));
      begin
        repeat (6) @(posedge clk);
        #1 ordy = 0;
        repeat (3) @(posedge clk);
        #1 ordy = 1;
      end
    join
    drain();
    repeat (20) send_rand(4);
    drain();
    rnd_bp = 1;
    repeat (60) send_rand(0);
    rnd_bp = 0;
    @(posedge clk);
    #1 ordy = 1;
    drain();
    repeat (3) send_rand(0);
    @(posedge clk);
    #2 reset = 1;
    q.delete();
    xa = $urandom;
    xb = $urandom;
    #1;
    chk("midrst_out_valid", i4.out_valid, 0);
    chk("midrst_sum", i4.sum, 0);
    chk("midrst_cout", i4.cout, 0);
    chk("midrst_ovf", i4.ovf, 0);
    chk("midrst_in_ready", i4.in_ready, 0);
    repeat (2) @(posedge clk);
    #2;
    tv = 0;
    reset = 0;
    @(negedge clk);
    chk("in_ready_after_midrst", ir, 1);
    repeat (12) @(negedge clk);
    chk("no_stale_result", ov, 0);
    sel = 1;
    foreach (dv[i]) issue(dv[i].a, dv[i].b, dv[i].ci, dv[i].sb, 1, mk(dv[i].es, dv[i].ec, dv[i].eo));
    drain();
    rnd_bp = 1;
    repeat (30) send_rand(0);
    rnd_bp = 0;
    @(posedge clk);
    #1 ordy = 1;
    drain();
    chk("final_queue_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
